// File: rtl/controlador_desalojo.sv
// Eviction/refill engine for one 4-way cache set: picks a victim, writes it back if dirty, refills it from memory.
// Define EVICT_STATS_EN to add saturating eviction and writeback-line counters.
module controlador_desalojo #(
  parameter int  TAG_W      = 8,
  parameter int  DATA_W     = 32,
  parameter int  LINE_WORDS = 4,
  localparam int WB         = $clog2(LINE_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_valid,
  output logic                  miss_ready,
  input  logic [TAG_W-1:0]      miss_tag,
  input  logic                  wr_hit,
  input  logic [1:0]            wr_hit_way,
  output logic [3:0]            way_valid,
  output logic [3:0]            way_dirty,
  output logic [4*TAG_W-1:0]    way_tag,
  input  logic [1:0]            victim_way,
  output logic                  arr_we,
  output logic [1:0]            arr_way,
  output logic [WB-1:0]         arr_word,
  output logic [DATA_W-1:0]     arr_wdata,
  input  logic [DATA_W-1:0]     arr_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [TAG_W+WB-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_rdata_valid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  done,
  output logic [1:0]            done_way
`ifdef EVICT_STATS_EN
  ,
  output logic [15:0]           evict_cnt,
  output logic [15:0]           wb_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_WB_RD, S_WB_REQ, S_FILL_REQ, S_FILL_WAIT, S_UPDATE
  } state_t;

  localparam logic [WB-1:0] LAST = WB'(LINE_WORDS - 1);

  state_t                   state_q, state_d;
  logic [3:0]               valid_q, valid_d;
  logic [3:0]               dirty_q, dirty_d;
  logic [3:0][TAG_W-1:0]    tag_q, tag_d;
  logic [1:0]               victim_q;
  logic                     vic_valid_q;
  logic [TAG_W-1:0]         old_tag_q;
  logic [TAG_W-1:0]         miss_tag_q;
  logic [WB-1:0]            k_q, j_q, r_q;
  logic [DATA_W-1:0]        hold_q;
  logic                     first_q;

  logic [1:0]               pick_way;
  logic                     pick_dirty;
  logic                     accept;
  logic                     wr_eff;
  logic                     fill_rx;

  // Lowest-index invalid way wins; the policy choice applies only to a full set.
  always_comb begin
    pick_way = victim_way;
    for (int i = 3; i >= 0; i--) begin
      if (!valid_q[i]) pick_way = 2'(i);
    end
  end

  assign accept     = miss_valid && (state_q == S_IDLE);
  assign wr_eff     = wr_hit && valid_q[wr_hit_way] &&
                      !((state_q != S_IDLE) && (wr_hit_way == victim_q));
  assign pick_dirty = dirty_q[pick_way] || (wr_eff && (wr_hit_way == pick_way));
  assign fill_rx    = mem_rdata_valid &&
                      ((state_q == S_FILL_REQ) || (state_q == S_FILL_WAIT));

  // NOTE: every always_comb assigns defaults first so no path can infer a latch.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    if (wr_eff) dirty_d[wr_hit_way] = 1'b1;
    if (state_q == S_UPDATE) begin
      valid_d[victim_q] = 1'b1;
      dirty_d[victim_q] = 1'b0;
      tag_d[victim_q]   = miss_tag_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (accept) state_d = pick_dirty ? S_WB_RD : S_FILL_REQ;
      S_WB_RD:     state_d = S_WB_REQ;
      S_WB_REQ:    if (mem_req_ready) state_d = (k_q == LAST) ? S_FILL_REQ : S_WB_RD;
      S_FILL_REQ:  if (mem_req_ready && (j_q == LAST)) state_d = S_FILL_WAIT;
      S_FILL_WAIT: if (mem_rdata_valid && (r_q == LAST)) state_d = S_UPDATE;
      S_UPDATE:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    miss_ready    = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = {miss_tag_q, j_q};
    arr_we        = 1'b0;
    arr_word      = r_q;
    done          = 1'b0;
    done_way      = 2'd0;
    case (state_q)
      S_IDLE:      miss_ready = 1'b1;
      S_WB_RD:     arr_word   = k_q;
      S_WB_REQ: begin
        arr_word      = k_q;
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {old_tag_q, k_q};
      end
      S_FILL_REQ: begin
        mem_req_valid = 1'b1;
        arr_we        = mem_rdata_valid;
      end
      S_FILL_WAIT: arr_we = mem_rdata_valid;
      S_UPDATE: begin
        done     = 1'b1;
        done_way = victim_q;
      end
      default: ;
    endcase
  end

  assign arr_way   = victim_q;
  assign arr_wdata = mem_rdata;
  // The array word is only valid in the first WB_REQ cycle; later cycles replay the held copy.
  assign mem_wdata = first_q ? arr_rdata : hold_q;

  // NOTE: the per-way state is plain flops, so it is cleared on reset like any other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      dirty_q     <= '0;
      tag_q       <= '0;
      victim_q    <= '0;
      vic_valid_q <= 1'b0;
      old_tag_q   <= '0;
      miss_tag_q  <= '0;
      k_q         <= '0;
      j_q         <= '0;
      r_q         <= '0;
      hold_q      <= '0;
      first_q     <= 1'b0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      tag_q   <= tag_d;
      first_q <= (state_q == S_WB_RD);
      if (first_q) hold_q <= arr_rdata;
      if (accept) begin
        victim_q    <= pick_way;
        vic_valid_q <= valid_q[pick_way];
        old_tag_q   <= tag_q[pick_way];
        miss_tag_q  <= miss_tag;
        k_q         <= '0;
        j_q         <= '0;
        r_q         <= '0;
      end
      if ((state_q == S_WB_REQ) && mem_req_ready)   k_q <= k_q + WB'(1);
      if ((state_q == S_FILL_REQ) && mem_req_ready) j_q <= j_q + WB'(1);
      if (fill_rx)                                  r_q <= r_q + WB'(1);
    end
  end

  assign way_valid = valid_q;
  assign way_dirty = dirty_q;
  assign way_tag   = tag_q;

`ifdef EVICT_STATS_EN
  logic [15:0] evict_cnt_q, wb_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      evict_cnt_q <= '0;
      wb_cnt_q    <= '0;
    end else begin
      if ((state_q == S_UPDATE) && vic_valid_q && (evict_cnt_q != 16'hFFFF))
        evict_cnt_q <= evict_cnt_q + 16'd1;
      if ((state_q == S_WB_REQ) && mem_req_ready && (k_q == LAST) && (wb_cnt_q != 16'hFFFF))
        wb_cnt_q <= wb_cnt_q + 16'd1;
    end
  end

  assign evict_cnt = evict_cnt_q;
  assign wb_cnt    = wb_cnt_q;
`endif

endmodule
